// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM state encodings,
// ready flag levels and start/stop request levels.
package div_pkg;

   localparam logic [1:0] DivFree   = 2'b00;
   localparam logic [1:0] DivByZero = 2'b01;
   localparam logic [1:0] DivOn     = 2'b10;
   localparam logic [1:0] DivEnd    = 2'b11;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   localparam int DivCntW = 6;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Result is {remainder, quotient}; signed mode divides magnitudes and fixes signs at the end.
module div
   import div_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   logic [1:0]          r_state;
   logic [DivCntW-1:0]  r_cnt;
   logic [DATA_W-1:0]   r_dividend;
   logic [DATA_W-1:0]   r_divisor;
   logic [DATA_W-1:0]   r_rem;
   logic                r_negQuo;
   logic                r_negRem;
   logic [2*DATA_W-1:0] r_result;
   logic                r_ready;

   logic                w_op1Neg;
   logic                w_op2Neg;
   logic [DATA_W-1:0]   w_op1Mag;
   logic [DATA_W-1:0]   w_op2Mag;
   logic [DATA_W:0]     w_trial;
   logic [DATA_W:0]     w_diff;
   logic                w_ge;
   logic [DATA_W-1:0]   w_remNext;
   logic [DATA_W-1:0]   w_quoNext;
   logic [DivCntW-1:0]  w_cntNext;
   logic                w_lastStep;
   logic [DATA_W-1:0]   w_quoFinal;
   logic [DATA_W-1:0]   w_remFinal;

   // Negating the most negative value wraps to itself, which is exactly its unsigned magnitude.
   assign w_op1Neg = signed_div_i & opdata1_i[DATA_W-1];
   assign w_op2Neg = signed_div_i & opdata2_i[DATA_W-1];
   assign w_op1Mag = w_op1Neg ? (~opdata1_i + 1'b1) : opdata1_i;
   assign w_op2Mag = w_op2Neg ? (~opdata2_i + 1'b1) : opdata2_i;

   // The dividend register doubles as the quotient shift register.
   assign w_trial   = {r_rem, r_dividend[DATA_W-1]};
   assign w_diff    = w_trial - {1'b0, r_divisor};
   assign w_ge      = (w_trial >= {1'b0, r_divisor});
   assign w_remNext = w_ge ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
   assign w_quoNext = {r_dividend[DATA_W-2:0], w_ge};

   assign w_cntNext  = r_cnt + 1'b1;
   assign w_lastStep = (w_cntNext == DivCntW'(DATA_W));

   assign w_quoFinal = r_negQuo ? (~w_quoNext + 1'b1) : w_quoNext;
   assign w_remFinal = r_negRem ? (~w_remNext + 1'b1) : w_remNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DivFree;
         r_cnt      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_negQuo   <= 1'b0;
         r_negRem   <= 1'b0;
         r_result   <= '0;
         r_ready    <= DivResultNotReady;
      end else begin
         case (r_state)
            DivFree: begin
               r_result <= '0;
               r_ready  <= DivResultNotReady;
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_state <= DivByZero;
                  end else begin
                     r_state    <= DivOn;
                     r_cnt      <= '0;
                     r_dividend <= w_op1Mag;
                     r_divisor  <= w_op2Mag;
                     r_rem      <= '0;
                     r_negQuo   <= w_op1Neg ^ w_op2Neg;
                     r_negRem   <= w_op1Neg;
                  end
               end
            end
            DivByZero: begin
               r_result <= '0;
               if (annul_i) begin
                  r_state <= DivFree;
                  r_ready <= DivResultNotReady;
               end else begin
                  r_state <= DivEnd;
                  r_ready <= DivResultReady;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  r_state  <= DivFree;
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_ready  <= DivResultNotReady;
               end else begin
                  r_dividend <= w_quoNext;
                  r_rem      <= w_remNext;
                  r_cnt      <= w_cntNext;
                  if (w_lastStep) begin
                     r_state  <= DivEnd;
                     r_result <= {w_remFinal, w_quoFinal};
                     r_ready  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  r_state  <= DivFree;
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_ready  <= DivResultNotReady;
               end
            end
            default: begin
               r_state  <= DivFree;
               r_result <= '0;
               r_ready  <= DivResultNotReady;
            end
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the divider: fixed vector table, hand-written
// annul/reset/by-zero sequences and random operands against an arithmetic model.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int testsRun;
   int testsFailed;

   typedef struct {
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          hold;
   } vec_t;

   vec_t vecs[10];

   div #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain 64-bit arithmetic; SV signed division truncates toward zero.
   function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint na, nb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'({32'd0, a});
         nb = longint'({32'd0, b});
      end
      q  = na / nb;
      r  = na % nb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: start held through ON while operands are scrambled, then held
   // in END for 'hold' cycles (with a stray annul), then dropped.
   task automatic applyStimulus(input string name, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] expRes, input int hold);
      int  edges;
      bit  seen;
      bit  earlyOut;
      logic [63:0] held;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      edges    = 0;
      seen     = 1'b0;
      earlyOut = 1'b0;
      while (!seen && edges < 40) begin
         tick();
         edges++;
         if (ready_o) seen = 1'b1;
         else begin
            if (result_o !== 64'd0) earlyOut = 1'b1;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
         end
      end
      checkOutput({name, " latency"}, 128'(edges), (b == 32'd0) ? 128'd2 : 128'd33);
      checkOutput({name, " result"}, 128'(result_o), 128'(expRes));
      checkOutput({name, " result zero before ready"}, 128'(earlyOut), 128'd0);
      held = result_o;
      for (int i = 0; i < hold; i++) begin
         annul_i = (i == 1);
         tick();
         checkOutput({name, " END hold"}, {63'd0, ready_o, result_o}, {63'd0, 1'b1, held});
      end
      start_i = 1'b0;
      annul_i = 1'b0;
      tick();
      checkOutput({name, " drop start"}, {63'd0, ready_o, result_o}, 128'd0);
   endtask

   initial begin
      bit          sawReady;
      bit          rs;
      logic [31:0] ra, rb;
      testsRun    = 0;
      testsFailed = 0;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h2, 32'hE},                 5};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},   0};
      vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0, 32'h80000000},          0};
      vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0, 32'hFFFFFFFF},          0};
      vecs[4] = '{1'b0, 32'd1234,       32'd0,        64'd0,                          2};
      vecs[5] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h0},          0};
      vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD},          0};
      vecs[7] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'h3},          0};
      vecs[8] = '{1'b0, 32'd5,          32'd10,       {32'h5, 32'h0},                 0};
      vecs[9] = '{1'b0, 32'd0,          32'd5,        64'd0,                          0};

      tick();
      tick();
      checkOutput("reset state", {63'd0, ready_o, result_o}, 128'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle after reset", {63'd0, ready_o, result_o}, 128'd0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
      end

      // Annul at step 10, then the follow-up divide must still work.
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      sawReady = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         tick();
         if (ready_o) sawReady = 1'b1;
      end
      annul_i = 1'b1;
      tick();
      checkOutput("annul outputs", {63'd0, ready_o, result_o}, 128'd0);
      start_i = 1'b0; annul_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o) sawReady = 1'b1;
      end
      checkOutput("annul no ready", 128'(sawReady), 128'd0);
      applyStimulus("after annul", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 0);

      // Annul during BYZERO.
      opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
      tick();
      annul_i = 1'b1;
      tick();
      checkOutput("annul byzero", {63'd0, ready_o, result_o}, 128'd0);
      start_i = 1'b0; annul_i = 1'b0;
      tick();

      // start with annul held in FREE must never launch a divide.
      opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
      sawReady = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o) sawReady = 1'b1;
      end
      checkOutput("start with annul", 128'(sawReady), 128'd0);
      start_i = 1'b0; annul_i = 1'b0;
      tick();

      // Reset at step 20 aborts silently.
      signed_div_i = 1'b1; opdata1_i = 32'hFFFF0000; opdata2_i = 32'd17; start_i = 1'b1;
      sawReady = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         tick();
         if (ready_o) sawReady = 1'b1;
      end
      rst = 1'b1; annul_i = 1'b1;
      tick();
      checkOutput("reset mid-op", {63'd0, ready_o, result_o}, 128'd0);
      rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o) sawReady = 1'b1;
      end
      checkOutput("reset no ready", 128'(sawReady), 128'd0);
      applyStimulus("after reset", 1'b1, 32'hFFFF0000, 32'd17, refDiv(1'b1, 32'hFFFF0000, 32'd17), 0);

      for (int n = 0; n < 20; n++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (n % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
         if (n == 7) rb = 32'd0;
         applyStimulus($sformatf("rand%0d", n), rs, ra, rb, refDiv(rs, ra, rb), n % 2);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
